// File: rtl/pixel_line_fifo.sv
// pixel_line_fifo: elastic line buffer between the USB pixel packer and the
// video timing generator. Primes to PREFILL entries, then pops one pixel per
// rd_en cycle with a one-cycle registered read. frame_start flushes the buffer.
// Optional build macro PIX_FIFO_STATS_EN adds saturating ovf_cnt/udf_cnt outputs.
//
// state  | meaning
// S_FILL | priming; rd_en ignored, rd_data held at BLANK_PIXEL
// S_RUN  | streaming; one pop per rd_en while not empty
module pixel_line_fifo #(
  parameter int                DATA_W      = 24,
  parameter int                ADDR_W      = 9,
  parameter int                PREFILL     = 256,
  parameter logic [DATA_W-1:0] BLANK_PIXEL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              rd_en,
  input  logic              frame_start,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              running,
`ifdef PIX_FIFO_STATS_EN
  output logic [15:0]       ovf_cnt,
  output logic [15:0]       udf_cnt,
`endif
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] PREFILL_L = (ADDR_W+1)'(PREFILL);

  typedef enum logic {S_FILL, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic [ADDR_W:0]     level_q, level_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                ovf_q, ovf_d, udf_q, udf_d;
  logic                push, pop, ovf_evt, udf_evt;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  assign full    = (level_q == DEPTH_L);
  assign empty   = (level_q == '0);
  assign running = (state_q == S_RUN);

  // Handshake decode; a flush cancels any pop and always takes the write into slot 0.
  always_comb begin
    pop     = running && rd_en && !empty && !frame_start;
    push    = wr_valid && (frame_start || !full || pop);
    ovf_evt = wr_valid && !push;
    udf_evt = running && rd_en && empty && !frame_start;
    wr_addr = frame_start ? '0 : wr_ptr_q;
  end

  // Next-state, pointer, level, read-data and flag logic.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
    level_d    = level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = (ovf_q & ~clr_flags) | ovf_evt;
    udf_d      = (udf_q & ~clr_flags) | udf_evt;
    if (frame_start) begin
      state_d   = S_FILL;
      wr_ptr_d  = ADDR_W'(push);
      rd_ptr_d  = '0;
      level_d   = (ADDR_W+1)'(push);
      rd_data_d = BLANK_PIXEL;
    end else begin
      case (state_q)
        S_FILL: begin
          rd_data_d = BLANK_PIXEL;
          if (level_q >= PREFILL_L) state_d = S_RUN;
        end
        S_RUN: begin
          if (udf_evt) begin
            rd_data_d = BLANK_PIXEL;
            state_d   = S_FILL;
          end else if (pop) begin
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  // Pixel storage; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= wr_data;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= BLANK_PIXEL;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign level         = level_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

`ifdef PIX_FIFO_STATS_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d, udf_cnt_q, udf_cnt_d;

  // Saturating event counters; a clear and a new event together leave a count of one.
  always_comb begin
    ovf_cnt_d = clr_flags ? 16'h0 : ovf_cnt_q;
    udf_cnt_d = clr_flags ? 16'h0 : udf_cnt_q;
    if (ovf_evt && ovf_cnt_d != 16'hFFFF) ovf_cnt_d = ovf_cnt_d + 16'h1;
    if (udf_evt && udf_cnt_d != 16'hFFFF) udf_cnt_d = udf_cnt_d + 16'h1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      udf_cnt_q <= udf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign udf_cnt = udf_cnt_q;
`endif

endmodule
